// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_pkg
// Purpose  : Shared types and constants for the regfile write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

   localparam int WORD_W = 64;

   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] wa;
      word_t      wd;
   } wb_req_t;

   typedef enum logic [0:0] {
      PIPE_PRI = 1'b0,
      DRAIN    = 1'b1
   } arb_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_fifo
// Purpose  : Small in-order FIFO of long-latency results with squash-by-address.
// Revision : 1.0 - initial release
// ============================================================================
module wb_result_fifo #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [4:0]                 push_wa,
   input  logic [DATA_W-1:0]          push_wd,
   input  logic                       pop,
   input  logic                       squash_en,
   input  logic [4:0]                 squash_wa,
   output logic                       head_valid,
   output logic [4:0]                 head_wa,
   output logic [DATA_W-1:0]          head_wd,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0]  r_valid;
   logic [4:0]        r_wa [DEPTH];
   logic [DATA_W-1:0] r_wd [DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;

   // A squash hits stored entries and an entry being pushed in the same
   // cycle alike: the squashing pipeline write is younger than both.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && (r_wa[i] == squash_wa))
               r_valid[i] <= 1'b0;
         end
         if (push) begin
            r_valid[r_wr_ptr] <= !(squash_en && (push_wa == squash_wa));
            r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
         end
         if (pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         r_wa[r_wr_ptr] <= push_wa;
         r_wd[r_wr_ptr] <= push_wd;
      end
   end

   assign head_valid = r_valid[r_rd_ptr];
   assign head_wa    = r_wa[r_rd_ptr];
   assign head_wd    = r_wd[r_rd_ptr];
   assign count      = r_count;
   assign full       = (r_count == CNT_W'(DEPTH));
   assign empty      = (r_count == '0);

endmodule : wb_result_fifo
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the regfile write port between pipeline writeback and a
//            long-latency unit. Optional macro WB_LU_BYPASS_EN lets an LU
//            result go straight to the regfile when the port and FIFO are idle.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_valid,
   input  logic [4:0]        pipe_wa,
   input  logic [DATA_W-1:0] pipe_wd,
   output logic              pipe_stall,
   input  logic              lu_valid,
   input  logic [4:0]        lu_wa,
   input  logic [DATA_W-1:0] lu_wd,
   output logic              lu_ready,
   output logic              rf_valid,
   output logic [4:0]        rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic              busy
);

   localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   arb_state_e          r_state, w_state_next;
   logic [STARVE_W-1:0] r_starve, w_starve_next;
   logic [CNT_W-1:0]    w_count, w_count_next;

   logic              w_push, w_pop, w_bypass, w_squash;
   logic              w_full, w_empty;
   logic              w_head_valid;
   logic [4:0]        w_head_wa;
   logic [DATA_W-1:0] w_head_wd;
   logic              w_pipe_wr, w_lu_live;

   assign w_pipe_wr = pipe_valid && (pipe_wa != REG_ZERO);
   assign w_lu_live = lu_valid && (lu_wa != REG_ZERO);

   wb_result_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (w_push),
      .push_wa    (lu_wa),
      .push_wd    (lu_wd),
      .pop        (w_pop),
      .squash_en  (w_squash),
      .squash_wa  (pipe_wa),
      .head_valid (w_head_valid),
      .head_wa    (w_head_wa),
      .head_wd    (w_head_wd),
      .count      (w_count),
      .full       (w_full),
      .empty      (w_empty)
   );

   always_comb begin
      w_pop      = 1'b0;
      w_bypass   = 1'b0;
      w_squash   = 1'b0;
      pipe_stall = 1'b0;
      rf_valid   = 1'b0;
      rf_wa      = REG_ZERO;
      rf_wd      = '0;
      if (!reset) begin
         unique case (r_state)
            PIPE_PRI: begin
               if (pipe_valid) begin
                  rf_valid = w_pipe_wr;
                  rf_wa    = pipe_wa;
                  rf_wd    = pipe_wd;
                  w_squash = w_pipe_wr;
               end else if (!w_empty) begin
                  w_pop    = 1'b1;
                  rf_valid = w_head_valid;
                  rf_wa    = w_head_wa;
                  rf_wd    = w_head_wd;
               end else begin
`ifdef WB_LU_BYPASS_EN
                  if (w_lu_live) begin
                     w_bypass = 1'b1;
                     rf_valid = 1'b1;
                     rf_wa    = lu_wa;
                     rf_wd    = lu_wd;
                  end
`endif
               end
            end
            DRAIN: begin
               // x0 writes never need the port, so they are never held.
               pipe_stall = w_pipe_wr;
               w_pop      = !w_empty;
               rf_valid   = !w_empty && w_head_valid;
               rf_wa      = w_head_wa;
               rf_wd      = w_head_wd;
            end
            default: ;
         endcase
      end
   end

   assign lu_ready = !reset && !w_full;
   assign w_push   = w_lu_live && lu_ready && !w_bypass;
   assign busy     = !reset && !w_empty;

   assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

   always_comb begin
      w_starve_next = r_starve;
      if (w_empty || w_pop)
         w_starve_next = '0;
      else if (r_starve != STARVE_W'(STARVE_MAX))
         w_starve_next = r_starve + STARVE_W'(1);
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         PIPE_PRI: begin
            if ((w_count_next == CNT_W'(FIFO_DEPTH)) ||
                (w_starve_next == STARVE_W'(STARVE_MAX)))
               w_state_next = DRAIN;
         end
         DRAIN: begin
            if (w_count_next == '0)
               w_state_next = PIPE_PRI;
         end
         default: w_state_next = PIPE_PRI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= PIPE_PRI;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_next;
         r_starve <= w_starve_next;
      end
   end

endmodule : wb_port_arbiter
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Directed self-checking bench for the regfile write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

   localparam int DATA_W = 64;

   logic              clk;
   logic              reset;
   logic              pipe_valid;
   logic [4:0]        pipe_wa;
   logic [DATA_W-1:0] pipe_wd;
   logic              pipe_stall;
   logic              lu_valid;
   logic [4:0]        lu_wa;
   logic [DATA_W-1:0] lu_wd;
   logic              lu_ready;
   logic              rf_valid;
   logic [4:0]        rf_wa;
   logic [DATA_W-1:0] rf_wd;
   logic              busy;

   int err_cnt = 0;
   int chk_cnt = 0;
   int x0_wr   = 0;
   int disc_wr = 0;
   logic [DATA_W-1:0] shadow [32];

   wb_port_arbiter #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (2),
      .STARVE_MAX (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pipe_valid (pipe_valid),
      .pipe_wa    (pipe_wa),
      .pipe_wd    (pipe_wd),
      .pipe_stall (pipe_stall),
      .lu_valid   (lu_valid),
      .lu_wa      (lu_wa),
      .lu_wd      (lu_wd),
      .lu_ready   (lu_ready),
      .rf_valid   (rf_valid),
      .rf_wa      (rf_wa),
      .rf_wd      (rf_wd),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shadow regfile built from the write port, plus counters of illegal writes.
   always @(posedge clk) begin
      if (!reset && rf_valid) begin
         shadow[rf_wa] <= rf_wd;
         if (rf_wa == 5'd0)
            x0_wr <= x0_wr + 1;
         if (rf_wa == 5'd21 || rf_wa == 5'd22)
            disc_wr <= disc_wr + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      pipe_valid = 1'b0; pipe_wa = 5'd0; pipe_wd = '0;
      lu_valid   = 1'b0; lu_wa   = 5'd0; lu_wd   = '0;
   endtask

   task automatic drive_pipe(input logic [4:0] wa, input logic [63:0] wd);
      pipe_valid = 1'b1; pipe_wa = wa; pipe_wd = wd;
   endtask

   task automatic drive_lu(input logic [4:0] wa, input logic [63:0] wd);
      lu_valid = 1'b1; lu_wa = wa; lu_wd = wd;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) shadow[i] = '0;
      idle();
      reset = 1'b1;
      drive_pipe(5'd9, 64'h99);
      drive_lu(5'd8, 64'h88);
      next_cycle();
      @(negedge clk);
      check("rst_rf_valid", rf_valid, 1'b0);
      check("rst_stall", pipe_stall, 1'b0);
      check("rst_lu_ready", lu_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      next_cycle();
      reset = 1'b0;
      idle();

      // Idle pipeline, single LU result
      drive_lu(5'd5, 64'h1234);
      @(negedge clk);
      check("t1_lu_ready", lu_ready, 1'b1);
`ifdef WB_LU_BYPASS_EN
      check("t1_bypass_valid", rf_valid, 1'b1);
      check("t1_bypass_wd", rf_wd, 64'h1234);
      next_cycle();
      idle();
      @(negedge clk);
      check("t1_busy", busy, 1'b0);
`else
      check("t1_no_write_yet", rf_valid, 1'b0);
      next_cycle();
      idle();
      @(negedge clk);
      check("t1_rf_valid", rf_valid, 1'b1);
      check("t1_rf_wa", rf_wa, 5'd5);
      check("t1_rf_wd", rf_wd, 64'h1234);
      check("t1_busy", busy, 1'b1);
      next_cycle();
      @(negedge clk);
      check("t1_busy_after", busy, 1'b0);
      check("t1_rf_idle", rf_valid, 1'b0);
`endif
      next_cycle();

      // Continuous pipeline, two LU pushes fill the FIFO and force a drain
      drive_pipe(5'd10, 64'hA0);
      drive_lu(5'd11, 64'hB1);
      @(negedge clk);
      check("t2_c0_wa", rf_wa, 5'd10);
      check("t2_c0_stall", pipe_stall, 1'b0);
      next_cycle();
      drive_pipe(5'd12, 64'hA1);
      drive_lu(5'd13, 64'hB3);
      @(negedge clk);
      check("t2_c1_wa", rf_wa, 5'd12);
      check("t2_c1_lu_ready", lu_ready, 1'b1);
      next_cycle();
      lu_valid = 1'b0;
      drive_pipe(5'd14, 64'hA2);
      @(negedge clk);
      check("t2_c2_stall", pipe_stall, 1'b1);
      check("t2_c2_wa", rf_wa, 5'd11);
      check("t2_c2_wd", rf_wd, 64'hB1);
      check("t2_c2_full", lu_ready, 1'b0);
      next_cycle();
      @(negedge clk);
      check("t2_c3_stall", pipe_stall, 1'b1);
      check("t2_c3_wa", rf_wa, 5'd13);
      check("t2_c3_wd", rf_wd, 64'hB3);
      next_cycle();
      @(negedge clk);
      check("t2_c4_stall", pipe_stall, 1'b0);
      check("t2_c4_wd", rf_wd, 64'hA2);
      check("t2_c4_busy", busy, 1'b0);
      next_cycle();

      // Starved head: waits STARVE_MAX cycles, then one stall cycle
      drive_pipe(5'd2, 64'h20);
      drive_lu(5'd20, 64'hC0);
      next_cycle();
      lu_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive_pipe(5'd3, 64'h30 + 64'(i));
         @(negedge clk);
         check("t3_wait_stall", pipe_stall, 1'b0);
         check("t3_wait_wd", rf_wd, 64'h30 + 64'(i));
         next_cycle();
      end
      @(negedge clk);
      check("t3_drain_stall", pipe_stall, 1'b1);
      check("t3_drain_wa", rf_wa, 5'd20);
      check("t3_drain_wd", rf_wd, 64'hC0);
      next_cycle();
      @(negedge clk);
      check("t3_after_stall", pipe_stall, 1'b0);
      check("t3_after_busy", busy, 1'b0);
      next_cycle();

      // WAW squash of a queued x7 result by a younger pipeline write
      drive_pipe(5'd3, 64'h33);
      drive_lu(5'd7, 64'h77);
      next_cycle();
      lu_valid = 1'b0;
      drive_pipe(5'd7, 64'h7777);
      @(negedge clk);
      check("t4_pipe_wa", rf_wa, 5'd7);
      check("t4_pipe_wd", rf_wd, 64'h7777);
      next_cycle();
      idle();
      @(negedge clk);
      check("t4_squashed_pop", rf_valid, 1'b0);
      check("t4_pop_busy", busy, 1'b1);
      next_cycle();
      @(negedge clk);
      check("t4_busy_after", busy, 1'b0);
      check("t4_x7_final", shadow[7], 64'h7777);
      next_cycle();

      // x0 from both sources
      drive_pipe(5'd0, 64'hDEAD);
      drive_lu(5'd0, 64'hBEEF);
      @(negedge clk);
      check("t5_lu_ready", lu_ready, 1'b1);
      check("t5_rf_valid", rf_valid, 1'b0);
      check("t5_stall", pipe_stall, 1'b0);
      next_cycle();
      idle();
      @(negedge clk);
      check("t5_no_enqueue", busy, 1'b0);
      next_cycle();

      // Reset with two entries queued
      drive_pipe(5'd4, 64'h40);
      drive_lu(5'd21, 64'hD1);
      next_cycle();
      drive_lu(5'd22, 64'hD2);
      next_cycle();
      lu_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_rf_valid", rf_valid, 1'b0);
      check("t6_rst_busy", busy, 1'b0);
      next_cycle();
      reset = 1'b0;
      idle();
      @(negedge clk);
      check("t6_busy", busy, 1'b0);
      check("t6_lu_ready", lu_ready, 1'b1);
      check("t6_rf_valid", rf_valid, 1'b0);
      next_cycle();
      @(negedge clk);
      check("t6_rf_valid2", rf_valid, 1'b0);
      next_cycle();
      check("t6_discarded_writes", 64'(disc_wr), 64'd0);
      check("x0_writes", 64'(x0_wr), 64'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule : tb_wb_port_arbiter
`default_nettype wire
